riscv_alu_arbiter: RTL

Shares one `riscv_alu` instance between two requesters: port 0 (core execute stage) and port 1 (auxiliary master, e.g. debug/address-generation unit). The block arbitrates the requests, drives the shared ALU combinationally from the granted request, and registers the result in a single-entry response buffer. The buffer is held until the owning requester accepts it. The block sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/riscv_alu_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter: shares one riscv_alu between port 0 (execute stage) and
// port 1 (auxiliary master). The granted request drives the ALU combinationally,
// and the ALU result is captured in a single-entry response buffer that is held
// until its owner consumes it.
// Optional feature macro: ALU_ARB_RR_EN (round-robin on conflict). Without it,
// port 0 has fixed priority.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_alu_arbiter (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic [`XLEN-1:0]   i_req0_a,
   input  logic [`XLEN-1:0]   i_req0_b,
   input  logic [3:0]         i_req0_ctrl,
   input  logic               i_req0_zcond,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic [`XLEN-1:0]   i_req1_a,
   input  logic [`XLEN-1:0]   i_req1_b,
   input  logic [3:0]         i_req1_ctrl,
   input  logic               i_req1_zcond,
   output logic               o_rsp0_valid,
   input  logic               i_rsp0_ready,
   output logic               o_rsp1_valid,
   input  logic               i_rsp1_ready,
   output logic [`XLEN-1:0]   o_rsp_result,
   output logic               o_rsp_zero,
   output logic [`XLEN-1:0]   o_alu_a,
   output logic [`XLEN-1:0]   o_alu_b,
   output logic [3:0]         o_alu_ctrl,
   output logic               o_alu_zcond,
   input  logic [`XLEN-1:0]   i_alu_result,
   input  logic               i_alu_zero
);

   // Idle ALU control code; matches ALU_CTRL_ADD of the riscv_alu encoding.
   localparam logic [3:0] ALU_CTRL_ADD = 4'b0000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL0 = 2'b01,
      ST_FULL1 = 2'b10
   } state_t;

   state_t state_r;
   logic   slot_free_s;
   logic   consumed_s;
   logic   conflict_pick1_s;
   logic   grant0_s;
   logic   grant1_s;

`ifdef ALU_ARB_RR_EN
   logic   last_grant_r;

   // Conflict winner is the port that was not granted last.
   always_comb begin
      conflict_pick1_s = ~last_grant_r;
   end

   // Remember which port was granted on every accept; reset favours port 0 next.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         last_grant_r <= 1'b1;
      end else if (grant0_s || grant1_s) begin
         last_grant_r <= grant1_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end
`else
   // Fixed priority: port 0 always wins a conflict.
   always_comb begin
      conflict_pick1_s = 1'b0;
   end
`endif

   // The buffer slot is free when empty or when its owner consumes it this cycle.
   always_comb begin
      slot_free_s = 1'b0;
      consumed_s  = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            slot_free_s = 1'b1;
            consumed_s  = 1'b0;
         end
         ST_FULL0: begin
            slot_free_s = i_rsp0_ready;
            consumed_s  = i_rsp0_ready;
         end
         ST_FULL1: begin
            slot_free_s = i_rsp1_ready;
            consumed_s  = i_rsp1_ready;
         end
         default: begin
            slot_free_s = 1'b1;
            consumed_s  = 1'b0;
         end
      endcase
   end

   // Grant one valid requester when the slot is free; nothing is granted in reset.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (i_rstn && slot_free_s) begin
         if (i_req0_valid && i_req1_valid) begin
            grant1_s = conflict_pick1_s;
            grant0_s = ~conflict_pick1_s;
         end else if (i_req0_valid) begin
            grant0_s = 1'b1;
         end else if (i_req1_valid) begin
            grant1_s = 1'b1;
         end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Ready mirrors the grant: a request is taken in the same cycle it is granted.
   always_comb begin
      o_req0_ready = grant0_s;
      o_req1_ready = grant1_s;
   end

   // Steer the granted request to the shared ALU, idle values otherwise.
   always_comb begin
      o_alu_a     = '0;
      o_alu_b     = '0;
      o_alu_ctrl  = ALU_CTRL_ADD;
      o_alu_zcond = 1'b0;
      if (grant0_s) begin
         o_alu_a     = i_req0_a;
         o_alu_b     = i_req0_b;
         o_alu_ctrl  = i_req0_ctrl;
         o_alu_zcond = i_req0_zcond;
      end else if (grant1_s) begin
         o_alu_a     = i_req1_a;
         o_alu_b     = i_req1_b;
         o_alu_ctrl  = i_req1_ctrl;
         o_alu_zcond = i_req1_zcond;
      end else begin
         o_alu_a     = '0;
         o_alu_b     = '0;
         o_alu_ctrl  = ALU_CTRL_ADD;
         o_alu_zcond = 1'b0;
      end
   end

   // Response buffer: capture on accept (replacing a consumed entry with no bubble),
   // empty on consume, otherwise hold. Result/zero keep their value when emptied.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r      <= ST_EMPTY;
         o_rsp0_valid <= 1'b0;
         o_rsp1_valid <= 1'b0;
         o_rsp_result <= '0;
         o_rsp_zero   <= 1'b0;
      end else if (grant0_s || grant1_s) begin
         state_r      <= grant1_s ? ST_FULL1 : ST_FULL0;
         o_rsp0_valid <= grant0_s;
         o_rsp1_valid <= grant1_s;
         o_rsp_result <= i_alu_result;
         o_rsp_zero   <= i_alu_zero;
      end else if (consumed_s) begin
         state_r      <= ST_EMPTY;
         o_rsp0_valid <= 1'b0;
         o_rsp1_valid <= 1'b0;
      end else begin
         state_r      <= state_r;
         o_rsp0_valid <= o_rsp0_valid;
         o_rsp1_valid <= o_rsp1_valid;
      end
   end

endmodule
